batch_dispatcher: RTL and testbench

- Schedules incoming transactions across NUM_BATCHES parallel batch filter engines (each fronted by its own conflict checker).
- Picks a target batch round-robin and issues a one-cycle dispatch pulse, then waits for that batch's accept/conflict verdict.
- On conflict or timeout, retries on the next untried batch; reports final accept/reject upstream.
- Sits between the transaction intake and the per-batch conflict_checker/filter_engine instances; the wide dependency vectors bypass it.

---
 rtl/batch_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_batch_dispatcher.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/batch_dispatcher.sv
// batch_dispatcher
//   Takes one transaction at a time from the intake and issues it to one of
//   NUM_BATCHES batch filter engines. The target is picked round-robin. The
//   dispatcher then waits for that batch's accept/conflict verdict. On
//   conflict or timeout it retries on the next untried, ready batch. The
//   final accept/reject is reported upstream with a one-cycle done pulse.
//
// Handshake semantics:
//   - Intake: a transaction transfers on a cycle with in_valid & in_ready.
//     in_ready is combinational and is high only in IDLE.
//   - Downstream: dispatch_valid is a one-cycle pulse and is not back-pressured.
//     Readiness is decided beforehand from batch_ready. Only the batch named
//     by dispatch_sel is listened to until it answers or the timeout expires.
//   - Upstream: done_valid is a one-cycle pulse and is not back-pressured.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_id, in_ready   transaction intake
//   batch_ready                 per-batch pipeline ready
//   dispatch_valid/_sel/_id     registered issue pulse, one-hot target, ID
//   batch_accept/_conflict      per-batch verdict pulses
//   done_valid/_accepted/_batch/_id  registered completion report
//   busy                        FSM not in IDLE
//   fsm_state                   current FSM state (debug visibility)
module batch_dispatcher #(
  parameter int NUM_BATCHES = 4,
  parameter int ID_W        = 64,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = $clog2(NUM_BATCHES),
  localparam int TMR_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [ID_W-1:0]        in_id,
  output logic                   in_ready,
  input  logic [NUM_BATCHES-1:0] batch_ready,
  output logic                   dispatch_valid,
  output logic [NUM_BATCHES-1:0] dispatch_sel,
  output logic [ID_W-1:0]        dispatch_id,
  input  logic [NUM_BATCHES-1:0] batch_accept,
  input  logic [NUM_BATCHES-1:0] batch_conflict,
  output logic                   done_valid,
  output logic                   done_accepted,
  output logic [IDX_W-1:0]       done_batch,
  output logic [ID_W-1:0]        done_id,
  output logic                   busy,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       cur_idx;
  logic [NUM_BATCHES-1:0] tried;
  logic [TMR_W-1:0]       timer;
  logic                   result_acc;

  logic [NUM_BATCHES-1:0] cand;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic                   resp_acc;
  logic                   resp_con;
  logic                   timed_out;

  assign cand      = batch_ready & ~tried;
  assign resp_acc  = batch_accept[cur_idx];
  assign resp_con  = batch_conflict[cur_idx];
  // The timer counts completed WAIT cycles. The batch has been silent for
  // TIMEOUT cycles once this cycle ends with the timer at TIMEOUT-1.
  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // First candidate at or after rr_ptr, wrapping around.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_BATCHES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_BATCHES) j = j - NUM_BATCHES;
      if (!pick_found && cand[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (in_valid) state_next = ISSUE;
      ISSUE: begin
        if (pick_found)  state_next = WAIT;
        else if (&tried) state_next = DONE;
      end
      WAIT: begin
        // Accept wins over a simultaneous conflict.
        if (resp_acc)                   state_next = DONE;
        else if (resp_con || timed_out) state_next = ISSUE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      cur_idx        <= '0;
      tried          <= '0;
      timer          <= '0;
      result_acc     <= 1'b0;
      dispatch_valid <= 1'b0;
      dispatch_sel   <= '0;
      dispatch_id    <= '0;
      done_valid     <= 1'b0;
      done_accepted  <= 1'b0;
      done_batch     <= '0;
      done_id        <= '0;
    end else begin
      dispatch_valid <= 1'b0;
      dispatch_sel   <= '0;
      done_valid     <= 1'b0;
      done_accepted  <= 1'b0;
      done_batch     <= '0;
      done_id        <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dispatch_id <= in_id;
            tried       <= '0;
            result_acc  <= 1'b0;
          end
        end
        ISSUE: begin
          if (pick_found) begin
            dispatch_valid  <= 1'b1;
            dispatch_sel    <= NUM_BATCHES'(1) << pick_idx;
            tried[pick_idx] <= 1'b1;
            cur_idx         <= pick_idx;
            timer           <= '0;
          end
        end
        WAIT: begin
          if (resp_acc) begin
            result_acc <= 1'b1;
            rr_ptr     <= (cur_idx == IDX_W'(NUM_BATCHES - 1)) ? '0 : cur_idx + 1'b1;
          end else if (timer != TMR_W'(TIMEOUT)) begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          done_valid    <= 1'b1;
          done_accepted <= result_acc;
          done_batch    <= result_acc ? cur_idx : '0;
          done_id       <= dispatch_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_batch_dispatcher.sv
// Directed testbench for batch_dispatcher (NUM_BATCHES=4, TIMEOUT=4).
module tb_batch_dispatcher;

  localparam int NB   = 4;
  localparam int IDW  = 64;
  localparam int TOUT = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [IDW-1:0] in_id;
  logic           in_ready;
  logic [NB-1:0]  batch_ready;
  logic           dispatch_valid;
  logic [NB-1:0]  dispatch_sel;
  logic [IDW-1:0] dispatch_id;
  logic [NB-1:0]  batch_accept;
  logic [NB-1:0]  batch_conflict;
  logic           done_valid;
  logic           done_accepted;
  logic [1:0]     done_batch;
  logic [IDW-1:0] done_id;
  logic           busy;
  logic [1:0]     fsm_state;

  int n_pass  = 0;
  int n_total = 0;

  batch_dispatcher #(.NUM_BATCHES(NB), .ID_W(IDW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_id(in_id), .in_ready(in_ready),
    .batch_ready(batch_ready),
    .dispatch_valid(dispatch_valid), .dispatch_sel(dispatch_sel), .dispatch_id(dispatch_id),
    .batch_accept(batch_accept), .batch_conflict(batch_conflict),
    .done_valid(done_valid), .done_accepted(done_accepted), .done_batch(done_batch),
    .done_id(done_id), .busy(busy), .fsm_state(fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".dv"},   64'(dispatch_valid), 64'd0);
    chk({tag, ".sel"},  64'(dispatch_sel),   64'd0);
    chk({tag, ".did"},  dispatch_id,         64'd0);
    chk({tag, ".donev"},64'(done_valid),     64'd0);
    chk({tag, ".acc"},  64'(done_accepted),  64'd0);
    chk({tag, ".dbat"}, 64'(done_batch),     64'd0);
    chk({tag, ".doid"}, done_id,             64'd0);
    chk({tag, ".busy"}, 64'(busy),           64'd0);
    chk({tag, ".rdy"},  64'(in_ready),       64'd1);
  endtask

  // Offer a transaction in IDLE; after the edge the FSM is in ISSUE.
  task automatic start_txn(input string tag, input logic [63:0] id);
    in_valid = 1'b1;
    in_id    = id;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_id    = '0;
    chk({tag, ".busy"},     64'(busy),     64'd1);
    chk({tag, ".in_ready0"},64'(in_ready), 64'd0);
  endtask

  // One edge later the registered dispatch pulse must be visible.
  task automatic expect_pulse(input string tag, input logic [3:0] sel, input logic [63:0] id);
    tick();
    chk({tag, ".dv"},  64'(dispatch_valid), 64'd1);
    chk({tag, ".sel"}, 64'(dispatch_sel),   64'(sel));
    chk({tag, ".did"}, dispatch_id,         id);
  endtask

  task automatic respond(input logic [3:0] acc, input logic [3:0] con);
    batch_accept   = acc;
    batch_conflict = con;
    tick();
    batch_accept   = '0;
    batch_conflict = '0;
  endtask

  // Called with the FSM in DONE; the pulse appears after the next edge.
  task automatic expect_done(input string tag, input logic acc, input logic [1:0] bat,
                             input logic [63:0] id);
    chk({tag, ".st_done"}, 64'(fsm_state),  64'(S_DONE));
    chk({tag, ".dv_pre"},  64'(done_valid), 64'd0);
    tick();
    chk({tag, ".done_v"},  64'(done_valid),    64'd1);
    chk({tag, ".done_a"},  64'(done_accepted), 64'(acc));
    chk({tag, ".done_b"},  64'(done_batch),    64'(bat));
    chk({tag, ".done_id"}, done_id,            id);
    chk({tag, ".idle"},    64'(busy),          64'd0);
    tick();
    chk({tag, ".done_v0"}, 64'(done_valid),    64'd0);
  endtask

  initial begin
    logic [3:0] conf_seq [4];
    conf_seq[0] = 4'b0100;
    conf_seq[1] = 4'b1000;
    conf_seq[2] = 4'b0001;
    conf_seq[3] = 4'b0010;

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_id          = '0;
    batch_ready    = 4'b1111;
    batch_accept   = '0;
    batch_conflict = '0;

    // reset state
    tick();
    tick();
    chk_reset_outputs("reset");
    chk("reset.state", 64'(fsm_state), 64'(S_IDLE));
    rst_n = 1'b1;
    tick();

    // T1: batch 0 accepts one cycle after the pulse
    start_txn("t1", 64'h11);
    expect_pulse("t1", 4'b0001, 64'h11);
    tick();
    chk("t1.dv_once", 64'(dispatch_valid), 64'd0);
    chk("t1.wait",    64'(fsm_state),      64'(S_WAIT));
    respond(4'b0001, 4'b0000);
    expect_done("t1", 1'b1, 2'd0, 64'h11);

    // T2: round-robin moves to batch 1; accept in the pulse cycle
    start_txn("t2", 64'h22);
    expect_pulse("t2", 4'b0010, 64'h22);
    respond(4'b0010, 4'b0000);
    expect_done("t2", 1'b1, 2'd1, 64'h22);

    // T3: every batch conflicts; second step carries a stray accept on batch 0
    start_txn("t3", 64'h33);
    for (int k = 0; k < 4; k++) begin
      expect_pulse($sformatf("t3.d%0d", k), conf_seq[k], 64'h33);
      if (k == 1) respond(4'b0001, conf_seq[k]);
      else        respond(4'b0000, conf_seq[k]);
      chk($sformatf("t3.iss%0d", k), 64'(fsm_state), 64'(S_ISSUE));
    end
    tick();
    chk("t3.no_more_dv", 64'(dispatch_valid), 64'd0);
    expect_done("t3", 1'b0, 2'd0, 64'h33);

    // T4: stall in ISSUE until batch 3 becomes ready; accept+conflict together
    batch_ready = 4'b0000;
    start_txn("t4", 64'h44);
    tick();
    chk("t4.stall_dv",  64'(dispatch_valid), 64'd0);
    chk("t4.stall_st",  64'(fsm_state),      64'(S_ISSUE));
    chk("t4.stall_bsy", 64'(busy),           64'd1);
    tick();
    chk("t4.stall_dv2", 64'(dispatch_valid), 64'd0);
    batch_ready = 4'b1000;
    expect_pulse("t4", 4'b1000, 64'h44);
    batch_ready = 4'b1111;
    respond(4'b1000, 4'b1000);
    expect_done("t4", 1'b1, 2'd3, 64'h44);

    // T5: batch 0 stays silent; after 4 WAIT cycles the FSM retries on batch 1
    start_txn("t5", 64'h55);
    expect_pulse("t5.a", 4'b0001, 64'h55);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t5.w%0d_dv", k), 64'(dispatch_valid), 64'd0);
      chk($sformatf("t5.w%0d_st", k), 64'(fsm_state),      64'(S_WAIT));
    end
    tick();
    chk("t5.to_issue", 64'(fsm_state),      64'(S_ISSUE));
    chk("t5.to_dv",    64'(dispatch_valid), 64'd0);
    expect_pulse("t5.b", 4'b0010, 64'h55);
    respond(4'b0010, 4'b0000);
    expect_done("t5", 1'b1, 2'd1, 64'h55);

    // T6: asynchronous reset while waiting on batch 2
    start_txn("t6", 64'h66);
    expect_pulse("t6", 4'b0100, 64'h66);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6.rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6.no_done%0d", k), 64'(done_valid), 64'd0);
      chk($sformatf("t6.rdy%0d", k),     64'(in_ready),   64'd1);
    end

    // T7: round-robin pointer restarted at batch 0
    start_txn("t7", 64'h77);
    expect_pulse("t7", 4'b0001, 64'h77);
    respond(4'b0001, 4'b0000);
    expect_done("t7", 1'b1, 2'd0, 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit reached");
  end

endmodule
